// File: rtl/cmp_pkg.sv
// Shared types for the comparator result unpacker: word classes, FSM states
// and the operand tags carried on the output stream.
package cmp_pkg;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_EQUAL  = 2'd1,
    CLS_TIE    = 2'd2,
    CLS_ERROR  = 2'd3
  } cls_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EMIT_MAX = 2'd1,
    ST_EMIT_HI  = 2'd2,
    ST_EMIT_LO  = 2'd3
  } state_e;

  localparam logic [1:0] TAG_MAX = 2'b00;
  localparam logic [1:0] TAG_HI  = 2'b01;
  localparam logic [1:0] TAG_LO  = 2'b10;

endpackage

// File: rtl/cmp_result_classify.sv
// Combinational classifier for one {OUT1,OUT2} comparator word pair.
// Resolves the class (TIE > EQUAL > NORMAL > ERROR) and recovers the three
// operands that the unpacker will serialise.
module cmp_result_classify
  import cmp_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [2*N-1:0] w1,
  input  logic [2*N-1:0] w2,
  output cls_e           cls,
  output logic [N-1:0]   max_o,
  output logic [N-1:0]   hi_o,
  output logic [N-1:0]   lo_o
);

  logic is_tie;
  logic is_eq;
  logic is_norm;

  // Class decode and operand recovery; EQUAL carries one operand in all three slots.
  always_comb begin
    is_tie  = (w1 == '0) && (w2 == '0);
    is_eq   = (w1[1:0] == 2'b00) && (w1[2*N-1:N+2] == '0) && (w2 == (w1 >> 4));
    is_norm = (w1[2*N-1:N] == {N{w1[N-1]}}) &&
              (w1[N-1:0] > w2[2*N-1:N]) &&
              (w1[N-1:0] > w2[N-1:0]);

    if (is_tie)       cls = CLS_TIE;
    else if (is_eq)   cls = CLS_EQUAL;
    else if (is_norm) cls = CLS_NORMAL;
    else              cls = CLS_ERROR;

    if (is_eq && !is_tie) begin
      max_o = w1[N+1:2];
      hi_o  = w1[N+1:2];
      lo_o  = w1[N+1:2];
    end else begin
      max_o = w1[N-1:0];
      hi_o  = w2[2*N-1:N];
      lo_o  = w2[N-1:0];
    end
  end

endmodule

// File: rtl/cmp_result_unpacker.sv
// Receive end of the 3-operand comparator result bus. Classifies each
// accepted word pair and streams MAX/HI/LO beats for NORMAL and EQUAL words.
// Optional feature macro: UNPACK_STATS_EN enables the saturating per-class
// counters; without it the cnt_* outputs are constant zero.
module cmp_result_unpacker
  import cmp_pkg::*;
#(
  parameter int N     = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_out1,
  input  logic [2*N-1:0]   in_out2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [1:0]       out_tag,
  output logic             out_last,
  output logic             err_sticky,
  input  logic             clr_err,
  output logic [CNT_W-1:0] cnt_norm,
  output logic [CNT_W-1:0] cnt_equal,
  output logic [CNT_W-1:0] cnt_tie,
  output logic [CNT_W-1:0] cnt_err
);

  cls_e         cls;
  logic [N-1:0] cls_max;
  logic [N-1:0] cls_hi;
  logic [N-1:0] cls_lo;

  state_e       state_q, state_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_data_q, out_data_d;
  logic [1:0]   out_tag_q, out_tag_d;
  logic         out_last_q, out_last_d;
  logic [N-1:0] hi_q, hi_d;
  logic [N-1:0] lo_q, lo_d;
  logic         err_q, err_d;

  logic accept;
  logic beat_done;

  cmp_result_classify #(.N(N)) u_classify (
    .w1    (in_out1),
    .w2    (in_out2),
    .cls   (cls),
    .max_o (cls_max),
    .hi_o  (cls_hi),
    .lo_o  (cls_lo)
  );

  assign in_ready   = (state_q == ST_IDLE);
  assign accept     = in_valid && in_ready;
  assign beat_done  = out_valid_q && out_ready;

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_tag    = out_tag_q;
  assign out_last   = out_last_q;
  assign err_sticky = err_q;

  // Next-state for the beat FSM; beat registers only change on accept or handshake.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_last_d  = out_last_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && ((cls == CLS_NORMAL) || (cls == CLS_EQUAL))) begin
          state_d     = ST_EMIT_MAX;
          out_valid_d = 1'b1;
          out_data_d  = cls_max;
          out_tag_d   = TAG_MAX;
          out_last_d  = 1'b0;
          hi_d        = cls_hi;
          lo_d        = cls_lo;
        end
      end
      ST_EMIT_MAX: begin
        if (beat_done) begin
          state_d    = ST_EMIT_HI;
          out_data_d = hi_q;
          out_tag_d  = TAG_HI;
        end
      end
      ST_EMIT_HI: begin
        if (beat_done) begin
          state_d    = ST_EMIT_LO;
          out_data_d = lo_q;
          out_tag_d  = TAG_LO;
          out_last_d = 1'b1;
        end
      end
      ST_EMIT_LO: begin
        if (beat_done) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky error: a new ERROR word outranks a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (accept && (cls == CLS_ERROR)) err_d = 1'b1;
    else if (clr_err)                 err_d = 1'b0;
  end

  // FSM, beat outputs and error flag; reset discards any pending beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= TAG_MAX;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  // Held HI/LO operands; only meaningful while a burst is in flight.
  always_ff @(posedge clk) begin
    hi_q <= hi_d;
    lo_q <= lo_d;
  end

`ifdef UNPACK_STATS_EN
  logic [CNT_W-1:0] cnt_norm_q, cnt_norm_d;
  logic [CNT_W-1:0] cnt_equal_q, cnt_equal_d;
  logic [CNT_W-1:0] cnt_tie_q, cnt_tie_d;
  logic [CNT_W-1:0] cnt_err_q, cnt_err_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic hit);
    if (hit && (cnt != {CNT_W{1'b1}})) return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    return cnt;
  endfunction

  // One increment per accepted word of the matching class, sticking at all-ones.
  always_comb begin
    cnt_norm_d  = sat_inc(cnt_norm_q,  accept && (cls == CLS_NORMAL));
    cnt_equal_d = sat_inc(cnt_equal_q, accept && (cls == CLS_EQUAL));
    cnt_tie_d   = sat_inc(cnt_tie_q,   accept && (cls == CLS_TIE));
    cnt_err_d   = sat_inc(cnt_err_q,   accept && (cls == CLS_ERROR));
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_norm_q  <= '0;
      cnt_equal_q <= '0;
      cnt_tie_q   <= '0;
      cnt_err_q   <= '0;
    end else begin
      cnt_norm_q  <= cnt_norm_d;
      cnt_equal_q <= cnt_equal_d;
      cnt_tie_q   <= cnt_tie_d;
      cnt_err_q   <= cnt_err_d;
    end
  end

  assign cnt_norm  = cnt_norm_q;
  assign cnt_equal = cnt_equal_q;
  assign cnt_tie   = cnt_tie_q;
  assign cnt_err   = cnt_err_q;
`else
  assign cnt_norm  = '0;
  assign cnt_equal = '0;
  assign cnt_tie   = '0;
  assign cnt_err   = '0;
`endif

endmodule

// File: tb/tb_cmp_result_unpacker.sv
// Bench for cmp_result_unpacker (N=5): directed cases followed by randomized
// word pairs, all checked against an arithmetic reference model.
module tb_cmp_result_unpacker;

  localparam int N     = 5;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef UNPACK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   in_out1;
  logic [2*N-1:0]   in_out2;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [1:0]       out_tag;
  logic             out_last;
  logic             err_sticky;
  logic             clr_err;
  logic [CNT_W-1:0] cnt_norm;
  logic [CNT_W-1:0] cnt_equal;
  logic [CNT_W-1:0] cnt_tie;
  logic [CNT_W-1:0] cnt_err;

  always #5 clk = ~clk;

  cmp_result_unpacker #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_out1    (in_out1),
    .in_out2    (in_out2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_last   (out_last),
    .err_sticky (err_sticky),
    .clr_err    (clr_err),
    .cnt_norm   (cnt_norm),
    .cnt_equal  (cnt_equal),
    .cnt_tie    (cnt_tie),
    .cnt_err    (cnt_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: class counts (unsaturated) and the sticky flag.
  int m_cnt[4];
  bit m_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt(input int c);
    return STATS ? ((c > CMAX) ? CMAX : c) : 0;
  endfunction

  // Class codes: 0 NORMAL, 1 EQUAL, 2 TIE, 3 ERROR.
  task automatic model(input int w1, input int w2,
                       output int cls, output int mx, output int hi, output int lo);
    int up, lw;
    up = w1 / 32;
    lw = w1 % 32;
    mx = lw; hi = w2 / 32; lo = w2 % 32;
    if (w1 == 0 && w2 == 0) cls = 2;
    else if ((w1 % 4) == 0 && (w1 / 128) == 0 && w2 == w1 / 16) begin
      cls = 1;
      mx = (w1 / 4) % 32; hi = mx; lo = mx;
    end else if (((lw >= 16) ? (up == 31) : (up == 0)) && lw > w2 / 32 && lw > w2 % 32)
      cls = 0;
    else cls = 3;
  endtask

  task automatic gen(input int kind, output logic [2*N-1:0] w1, output logic [2*N-1:0] w2);
    int m, a, h, l;
    case (kind)
      0: begin
        m = $urandom_range(1, 31);
        h = $urandom_range(0, m - 1);
        l = $urandom_range(0, m - 1);
        w1 = 10'(m >= 16 ? (31 * 32 + m) : m);
        w2 = 10'(h * 32 + l);
      end
      1: begin
        a  = $urandom_range(0, 31);
        w1 = 10'(a * 4);
        w2 = 10'(a / 4);
      end
      2: begin
        w1 = '0;
        w2 = '0;
      end
      default: begin
        w1 = 10'($urandom_range(0, 1023));
        w2 = 10'($urandom_range(0, 1023));
      end
    endcase
  endtask

  task automatic check_side(input string tag);
    chk({tag, ":cnt_norm"},  cnt_norm,  exp_cnt(m_cnt[0]));
    chk({tag, ":cnt_equal"}, cnt_equal, exp_cnt(m_cnt[1]));
    chk({tag, ":cnt_tie"},   cnt_tie,   exp_cnt(m_cnt[2]));
    chk({tag, ":cnt_err"},   cnt_err,   exp_cnt(m_cnt[3]));
    chk({tag, ":err_sticky"}, err_sticky, m_err);
  endtask

  // Offer one word pair, then consume and check its beats.
  // stall_beat 0..2 holds out_ready low for stall_n cycles on that beat; 3 = no stall.
  task automatic run_word(input string tag, input logic [2*N-1:0] w1, input logic [2*N-1:0] w2,
                          input bit clr, input int stall_beat, input int stall_n);
    int cls, mx, hi, lo, n;
    int exp_d[3];
    model(int'(w1), int'(w2), cls, mx, hi, lo);
    n = 0;
    while (!in_ready && n < 16) begin
      tick();
      n++;
    end
    chk({tag, ":in_ready_wait"}, in_ready, 1);
    in_valid = 1'b1; in_out1 = w1; in_out2 = w2; clr_err = clr;
    tick();
    in_valid = 1'b0; clr_err = 1'b0;
    m_cnt[cls]++;
    if (cls == 3) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (cls <= 1) begin
      exp_d[0] = mx; exp_d[1] = hi; exp_d[2] = lo;
      for (int b = 0; b < 3; b++) begin
        if (b == stall_beat) begin
          out_ready = 1'b0;
          for (int k = 0; k < stall_n; k++) begin
            chk({tag, ":hold_valid"}, out_valid, 1);
            chk({tag, ":hold_data"}, out_data, exp_d[b]);
            tick();
          end
        end
        out_ready = 1'b1;
        chk({tag, ":valid"}, out_valid, 1);
        chk({tag, ":busy"}, in_ready, 0);
        chk({tag, ":data"}, out_data, exp_d[b]);
        chk({tag, ":tag"}, out_tag, b);
        chk({tag, ":last"}, out_last, (b == 2));
        tick();
      end
      out_ready = 1'b0;
    end
    chk({tag, ":valid_done"}, out_valid, 0);
    chk({tag, ":ready_done"}, in_ready, 1);
    check_side(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d", total);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [2*N-1:0] w1, w2;
    int kind;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_err = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_out1 = '0; in_out2 = '0;
    out_ready = 1'b0; clr_err = 1'b0;
    tick(); tick();
    chk("rst:out_valid", out_valid, 0);
    chk("rst:out_data", out_data, 0);
    chk("rst:out_tag", out_tag, 0);
    chk("rst:out_last", out_last, 0);
    chk("rst:in_ready", in_ready, 1);
    check_side("rst");
    rst_n = 1'b1;
    tick();

    run_word("normal", 10'h003, 10'h041, 1'b0, 3, 0);
    run_word("normal_neg", 10'h3F0, 10'h041, 1'b0, 3, 0);
    run_word("equal", 10'h018, 10'h001, 1'b0, 3, 0);
    run_word("tie", 10'h000, 10'h000, 1'b0, 3, 0);
    run_word("error", 10'h3E0, 10'h000, 1'b0, 3, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    m_err = 1'b0;
    chk("clr_err", err_sticky, 0);
    run_word("error_again", 10'h3E0, 10'h000, 1'b0, 3, 0);
    run_word("error_vs_clr", 10'h3E0, 10'h000, 1'b1, 3, 0);
    run_word("stall_hi", 10'h003, 10'h041, 1'b0, 1, 3);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      gen(kind, w1, w2);
      run_word("rand", w1, w2, ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(1, 2));
    end

    // Reset asserted while the HI beat is pending.
    run_word("pre_rst", 10'h3E0, 10'h000, 1'b0, 3, 0);
    in_valid = 1'b1; in_out1 = 10'h003; in_out2 = 10'h041;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("mid:data_hi", out_data, 2);
    chk("mid:tag_hi", out_tag, 1);
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_err = 1'b0;
    chk("mid_rst:out_valid", out_valid, 0);
    chk("mid_rst:in_ready", in_ready, 1);
    chk("mid_rst:out_data", out_data, 0);
    chk("mid_rst:out_tag", out_tag, 0);
    chk("mid_rst:out_last", out_last, 0);
    check_side("mid_rst");
    rst_n = 1'b1;
    tick();

    // Enough NORMAL words to push the counter past its top value.
    for (int i = 0; i < 258; i++) begin
      gen(0, w1, w2);
      run_word("sat", w1, w2, 1'b0, 3, 0);
    end
    chk("sat:final", cnt_norm, STATS ? 8'hFF : 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
